// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit path
//
// Holds the transmit FSM state encoding (3-bit), the default frame data
// width and the parity type encodings used by uart_tx_fsm and parity_calc.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fsm_parity_calc.sv
// rtl/uart_tx_fsm_parity_calc.sv - parity bit generator for the UART transmit FSM
//
// Compiled only when UART_PARITY_EN is defined.
// Ports:
//   data_i     latched frame byte
//   par_typ_i  parity type (PAR_EVEN / PAR_ODD)
//   par_bit_o  parity bit to place on the line
`ifdef UART_PARITY_EN
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  // Even parity is the plain XOR reduction; odd parity inverts it.
  assign par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule
`endif

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit framing FSM (start, data, optional parity, stop)
//
// Build option: UART_PARITY_EN compiles in the PARITY state and parity_calc.
// Without it PAR_EN/PAR_TYP are accepted but ignored and frames are 10 cycles.
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   P_DATA      byte to transmit, latched on accept
//   Data_Valid  send request, honoured only in IDLE
//   PAR_EN      parity enable, latched on accept
//   PAR_TYP     parity type (0 even, 1 odd), latched on accept
//   Ser_Data    current data bit from the external serializer
//   Ser_Done    serializer is presenting its last data bit
//   Ser_En      advance the serializer (DATA state only)
//   TX_OUT      serial line, idle high
//   Busy        frame in progress
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Ser_Data,
  input  logic                  Ser_Done,
  output logic                  Ser_En,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

`ifdef UART_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic par_bit;

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .par_bit_o (par_bit)
  );
`else
  // Parity inputs and the latched byte have no consumer in this build.
  logic unused_par;
  assign unused_par = ^{PAR_EN, PAR_TYP, data_q};
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
`ifdef UART_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
`ifdef UART_PARITY_EN
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
`ifdef UART_PARITY_EN
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
`endif
    Ser_En    = 1'b0;
    TX_OUT    = 1'b1;
    Busy      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        Busy = 1'b0;
        if (Data_Valid) begin
          data_d    = P_DATA;
`ifdef UART_PARITY_EN
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
`endif
          state_d   = ST_START;
        end
      end
      ST_START: begin
        TX_OUT  = 1'b0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        Ser_En = 1'b1;
        TX_OUT = Ser_Data;
        if (Ser_Done) begin
`ifdef UART_PARITY_EN
          state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        TX_OUT  = par_bit;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        TX_OUT  = 1'b1;
        state_d = ST_IDLE;
      end
      // Unused encodings (and PARITY when not built) fall back to IDLE.
      default: begin
        Busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - self-checking bench for uart_tx_fsm
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       Ser_Data;
  logic       Ser_Done;
  logic       Ser_En;
  logic       TX_OUT;
  logic       Busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  uart_tx_fsm #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Ser_Data   (Ser_Data),
    .Ser_Done   (Ser_Done),
    .Ser_En     (Ser_En),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

`ifdef UART_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  // Behavioural serializer: bytes queued by the bench, shifted out LSB first.
  logic [7:0] byte_mem [16];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr;
  logic [2:0] bit_idx;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr  <= wr_ptr;
      bit_idx <= 3'd0;
    end else if (Ser_En) begin
      bit_idx <= bit_idx + 3'd1;
      if (bit_idx == 3'd7) rd_ptr <= rd_ptr + 4'd1;
    end
  end

  assign Ser_Data = byte_mem[rd_ptr][bit_idx];
  assign Ser_Done = (bit_idx == 3'd7);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef bit frame_t[$];

  // Reference line sequence: start 0, data LSB first, optional parity, stop 1.
  function automatic frame_t model_frame(input logic [7:0] d, input bit pe, input bit pt);
    frame_t f;
    int ones;
    ones = $countones(d);
    f.push_back(1'b0);
    for (int i = 0; i < 8; i++) f.push_back(d[i]);
    if (PAR_BUILT && pe) f.push_back(1'((ones % 2) ^ int'(pt)));
    f.push_back(1'b1);
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] d);
    byte_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Called at a negedge while the DUT is idle; request is taken on the next posedge.
  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit hold);
    push_byte(d);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) Data_Valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input bit pe, input bit pt);
    frame_t f;
    int en_cnt;
    f = model_frame(d, pe, pt);
    en_cnt = 0;
    for (int i = 0; i < f.size(); i++) begin
      @(negedge CLK);
      check_eq({tag, "/tx"}, 32'(TX_OUT), 32'(f[i]));
      check_eq({tag, "/busy"}, 32'(Busy), 32'd1);
      check_eq({tag, "/ser_en"}, 32'(Ser_En), 32'(i >= 1 && i <= 8));
      if (Ser_En) en_cnt++;
    end
    check_eq({tag, "/ser_en_cnt"}, 32'(en_cnt), 32'd8);
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK);
    check_eq({tag, "/idle_busy"}, 32'(Busy), 32'd0);
    check_eq({tag, "/idle_tx"}, 32'(TX_OUT), 32'd1);
    check_eq({tag, "/idle_ser_en"}, 32'(Ser_En), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    bit pe, pt;
    int gap;

    repeat (3) @(negedge CLK);
    check_eq("rst_tx", 32'(TX_OUT), 32'd1);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_ser_en", 32'(Ser_En), 32'd0);

    // First request lands on the first rising edge after release.
    RST = 1'b1;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame("a5_even", 8'hA5, 1'b1, 1'b0);
    check_idle("a5_even");

    @(negedge CLK);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    check_frame("01_odd", 8'h01, 1'b1, 1'b1);
    check_idle("01_odd");

    @(negedge CLK);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    check_frame("01_even", 8'h01, 1'b1, 1'b0);
    check_idle("01_even");

    @(negedge CLK);
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    check_frame("ff_nopar", 8'hFF, 1'b0, 1'b0);
    check_idle("ff_nopar");

    // Request held high with new data through the whole first frame.
    @(negedge CLK);
    send(8'h55, 1'b1, 1'b0, 1'b1);
    P_DATA = 8'h3C;
    push_byte(8'h3C);
    check_frame("b2b_55", 8'h55, 1'b1, 1'b0);
    check_idle("b2b_gap");
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    check_frame("b2b_3c", 8'h3C, 1'b1, 1'b0);
    check_idle("b2b_3c");

    // Asynchronous reset in the middle of the 4th data bit.
    @(negedge CLK);
    send(8'hC3, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge CLK);
    check_eq("midrst_pre_busy", 32'(Busy), 32'd1);
    check_eq("midrst_pre_ser_en", 32'(Ser_En), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check_eq("midrst_tx", 32'(TX_OUT), 32'd1);
    check_eq("midrst_busy", 32'(Busy), 32'd0);
    check_eq("midrst_ser_en", 32'(Ser_En), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    send(8'h0F, 1'b1, 1'b0, 1'b0);
    check_frame("after_rst_0f", 8'h0F, 1'b1, 1'b0);
    check_idle("after_rst_0f");

    for (int k = 0; k < 20; k++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge CLK);
      @(negedge CLK);
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      send(d, pe, pt, 1'b0);
      check_frame($sformatf("rnd%0d_%02h", k, d), d, pe, pt);
      check_idle($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
